// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single integer register-file write port among REQ_NUM writeback
// requesters. A round-robin grant feeds a one-entry registered output stage
// with a valid/ready handshake toward the register file.
//
// Ports:
//   CLK, RSTn   clock (rising edge) and asynchronous active-low reset
//   req_valid   per-requester write request
//   req_ready   per-requester grant, one-hot or zero (combinational)
//   req_addr    packed destination addresses, requester i at [i*AW +: AW]
//   req_data    packed write data, requester i at [i*DW +: DW]
//   wr_valid    registered write toward the register file is valid
//   wr_ready    register file accepts the write this cycle
//   wr_addr     registered write address
//   wr_data     registered write data
//   flush       blocks new grants this cycle; the held entry still drains
module wb_port_arbiter #(
    parameter int unsigned REQ_NUM = 4,
    parameter int unsigned DW      = 64,
    parameter int unsigned AW      = 6
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [REQ_NUM-1:0]    req_valid,
    output logic [REQ_NUM-1:0]    req_ready,
    input  logic [REQ_NUM*AW-1:0] req_addr,
    input  logic [REQ_NUM*DW-1:0] req_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [AW-1:0]         wr_addr,
    output logic [DW-1:0]         wr_data,
    input  logic                  flush
);

    localparam int unsigned PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          wr_valid_q, wr_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          accept;
    logic          gnt_found;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] scan_idx;
    logic          xfer;

    logic [AW-1:0] addr_arr [REQ_NUM];
    logic [DW-1:0] data_arr [REQ_NUM];

    // Unpack the flat request buses so the granted slot can be selected by index.
    for (genvar i = 0; i < int'(REQ_NUM); i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // RSTn gates accept so no grant is visible while reset is held.
    assign accept = RSTn & ~flush & (~wr_valid_q | wr_ready);
    assign xfer   = accept & gnt_found;

    // Round-robin scan: first valid requester starting at ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            scan_idx = PW'((32'(ptr_q) + k) % REQ_NUM);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Next state of the pointer and the output stage.
    always_comb begin
        ptr_d      = ptr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (xfer) begin
            ptr_d = PW'((32'(gnt_idx) + 32'd1) % REQ_NUM);
            if (addr_arr[gnt_idx] != '0) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_arr[gnt_idx];
                wr_data_d  = data_arr[gnt_idx];
            end else begin
                // Writes to the zero register are consumed and dropped; accept
                // guarantees the stage is empty or draining this cycle.
                wr_valid_d = 1'b0;
            end
        end else if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end
    end

    // Grant output: one-hot on the winner, zero when not accepting.
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
